alu_seq: RTL



---
 rtl/alu_seq.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with NZCV flags, iterative unsigned multiply/divide, start/done handshake
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic [3:0]       status
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SLL  = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_MULU = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1101;

   logic [1:0]       state_q, state_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [3:0]       status_q, status_d;

   logic [WIDTH:0]   sum_add, sum_sub;
   logic             v_add, v_sub;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_acc, mul_lo;
   logic [WIDTH:0]   div_sh;
   logic [WIDTH-1:0] div_diff, div_acc, div_lo;
   logic             div_ok;

   // Single-cycle datapath; SUB and SLT share the a + ~b + 1 adder so C means "no borrow"
   always_comb begin
      sum_add = {1'b0, a} + {1'b0, b};
      sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      v_add   = (a[WIDTH-1] == b[WIDTH-1]) & (sum_add[WIDTH-1] ^ a[WIDTH-1]);
      v_sub   = (a[WIDTH-1] ^ b[WIDTH-1]) & (sum_sub[WIDTH-1] ^ a[WIDTH-1]);
      shamt   = a[SHW-1:0];
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op)
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_ADD: begin
            alu_res = sum_add[WIDTH-1:0];
            alu_c   = sum_add[WIDTH];
            alu_v   = v_add;
         end
         OP_SUB: begin
            alu_res = sum_sub[WIDTH-1:0];
            alu_c   = sum_sub[WIDTH];
            alu_v   = v_sub;
         end
         OP_SLT: begin
            alu_res = {{(WIDTH-1){1'b0}}, sum_sub[WIDTH-1] ^ v_sub};
            alu_c   = sum_sub[WIDTH];
            alu_v   = v_sub;
         end
         OP_SLL: alu_res = b << shamt;
         OP_SRL: alu_res = b >> shamt;
         OP_SRA: alu_res = WIDTH'($signed(b) >>> shamt);
         default: alu_res = '0;
      endcase
   end

   // One multiply step shifts {acc,lo} right; one divide step shifts {acc,lo} left
   always_comb begin
      mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
      mul_acc  = mul_sum[WIDTH:1];
      mul_lo   = {mul_sum[0], lo_q[WIDTH-1:1]};
      div_sh   = {acc_q, lo_q[WIDTH-1]};
      div_ok   = (div_sh >= {1'b0, opb_q});
      div_diff = div_sh[WIDTH-1:0] - opb_q;
      div_acc  = div_ok ? div_diff : div_sh[WIDTH-1:0];
      div_lo   = {lo_q[WIDTH-2:0], div_ok};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      lo_d     = lo_q;
      opb_d    = opb_q;
      result_d = result_q;
      hi_d     = hi_q;
      status_d = status_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (op == OP_MULU) begin
                  state_d = S_MUL;
                  acc_d   = '0;
                  lo_d    = a;
                  opb_d   = b;
                  cnt_d   = SHW'(WIDTH-1);
               end else if (op == OP_DIVU && b != '0) begin
                  state_d = S_DIV;
                  acc_d   = '0;
                  lo_d    = a;
                  opb_d   = b;
                  cnt_d   = SHW'(WIDTH-1);
               end else if (op == OP_DIVU) begin
                  state_d  = S_DONE;
                  result_d = '1;
                  hi_d     = a;
                  status_d = 4'b1010;
               end else begin
                  state_d  = S_DONE;
                  result_d = alu_res;
                  hi_d     = '0;
                  status_d = {alu_v, alu_c, alu_res[WIDTH-1], alu_res == '0};
               end
            end
         end
         S_MUL: begin
            acc_d = mul_acc;
            lo_d  = mul_lo;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d  = S_DONE;
               result_d = mul_lo;
               hi_d     = mul_acc;
               status_d = {mul_acc != '0, 1'b0, mul_lo[WIDTH-1], mul_lo == '0};
            end
         end
         S_DIV: begin
            acc_d = div_acc;
            lo_d  = div_lo;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d  = S_DONE;
               result_d = div_lo;
               hi_d     = div_acc;
               status_d = {2'b00, div_lo[WIDTH-1], div_lo == '0};
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         lo_q     <= '0;
         opb_q    <= '0;
         result_q <= '0;
         hi_q     <= '0;
         status_q <= 4'b0000;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         lo_q     <= lo_d;
         opb_q    <= opb_d;
         result_q <= result_d;
         hi_q     <= hi_d;
         status_q <= status_d;
      end
   end

   assign busy   = (state_q == S_MUL) || (state_q == S_DIV);
   assign done   = (state_q == S_DONE);
   assign result = result_q;
   assign hi     = hi_q;
   assign status = status_q;

endmodule
